// File: rtl/gauss1d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : gauss1d_stream
//  Description : Streaming 1-D Gaussian smoother. Builds a 7-sample sliding
//                window with replicate borders at both ends of each line and
//                applies a 7-tap [1,8,14,18,14,8,1] or 5-tap [1,4,6,4,1]
//                kernel, selected per line. Two-stage pipelined output,
//                optionally normalised by the kernel gain (round-half-up).
//  Revision    : 1.0 - initial release
// ============================================================================
module gauss1d_stream #(
    parameter int DATA_WIDTH = 14,
    parameter int NORMALIZE  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_sample_valid,
    input  logic [DATA_WIDTH-1:0]   in_sample_value,
    input  logic                    in_last,
    input  logic                    in_mode,
    output logic                    in_ready,
    output logic [DATA_WIDTH+5:0]   out_event_value,
    output logic                    out_event_valid
);

    localparam int OW = DATA_WIDTH + 6;
    localparam int PW = DATA_WIDTH + 1;

    // Half-kernel widths: number of right-replicate shifts needed per line
    localparam logic [1:0] C_H7 = 2'd3;
    localparam logic [1:0] C_H5 = 2'd2;

    // Kernel weights and rounding offsets at full output width
    localparam logic [OW-1:0] C_K4  = OW'(4);
    localparam logic [OW-1:0] C_K6  = OW'(6);
    localparam logic [OW-1:0] C_K8  = OW'(8);
    localparam logic [OW-1:0] C_K14 = OW'(14);
    localparam logic [OW-1:0] C_K18 = OW'(18);
    localparam logic [OW-1:0] C_R8  = OW'(8);
    localparam logic [OW-1:0] C_R32 = OW'(32);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Window / control state
    // ------------------------------------------------------------------
    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   win_q [0:6];
    logic                    mode_q;     // 1 = 5-tap for the current line
    logic [1:0]              cnt_q;      // index of the next shift, saturates at H
    logic [1:0]              fcnt_q;     // flush cycles already performed
    logic                    emit_q;     // window just updated holds an output
    logic                    emode_q;    // kernel for the window in emit_q
    logic                    ready_q;

    logic                    accept;
    logic [1:0]              h_cur;

    assign accept   = in_sample_valid && ready_q;
    assign h_cur    = mode_q ? C_H5 : C_H7;
    assign in_ready = ready_q;

    // Line FSM: loads/shifts the window, counts shifts and flags output windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 7; i++) begin
                win_q[i] <= '0;
            end
            mode_q  <= 1'b0;
            cnt_q   <= 2'd0;
            fcnt_q  <= 2'd0;
            emit_q  <= 1'b0;
            emode_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            emit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        // Shift 0: left-replicate the first sample across the window
                        for (int i = 0; i < 7; i++) begin
                            win_q[i] <= in_sample_value;
                        end
                        mode_q  <= in_mode;
                        emode_q <= in_mode;
                        cnt_q   <= 2'd1;
                        if (in_last) begin
                            state_q <= ST_FLUSH;
                            fcnt_q  <= 2'd0;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        for (int i = 0; i < 6; i++) begin
                            win_q[i] <= win_q[i+1];
                        end
                        win_q[6] <= in_sample_value;
                        emit_q   <= (cnt_q == h_cur);
                        emode_q  <= mode_q;
                        if (cnt_q != h_cur) begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                        if (in_last) begin
                            state_q <= ST_FLUSH;
                            fcnt_q  <= 2'd0;
                            ready_q <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Right-replicate: w[6] keeps the last sample of the line
                    for (int i = 0; i < 6; i++) begin
                        win_q[i] <= win_q[i+1];
                    end
                    emit_q  <= (cnt_q == h_cur);
                    emode_q <= mode_q;
                    if (cnt_q != h_cur) begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                    fcnt_q <= fcnt_q + 2'd1;
                    if (fcnt_q == (h_cur - 2'd1)) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: symmetric pair sums
    // ------------------------------------------------------------------
    logic [PW-1:0]           pair_a_q;   // outermost pair
    logic [PW-1:0]           pair_b_q;
    logic [PW-1:0]           pair_c_q;   // innermost pair (7-tap only)
    logic [DATA_WIDTH-1:0]   ctr_q;
    logic                    pv_q;
    logic                    pmode_q;

    // Fold the window around its centre so each weight multiplies once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_a_q <= '0;
            pair_b_q <= '0;
            pair_c_q <= '0;
            ctr_q    <= '0;
            pv_q     <= 1'b0;
            pmode_q  <= 1'b0;
        end else begin
            pv_q    <= emit_q;
            pmode_q <= emode_q;
            if (!emit_q) begin
                pair_a_q <= '0;
                pair_b_q <= '0;
                pair_c_q <= '0;
                ctr_q    <= '0;
            end else if (emode_q) begin
                // 5-tap spans w[2..6], centred on w[4]
                pair_a_q <= {1'b0, win_q[2]} + {1'b0, win_q[6]};
                pair_b_q <= {1'b0, win_q[3]} + {1'b0, win_q[5]};
                pair_c_q <= '0;
                ctr_q    <= win_q[4];
            end else begin
                pair_a_q <= {1'b0, win_q[0]} + {1'b0, win_q[6]};
                pair_b_q <= {1'b0, win_q[1]} + {1'b0, win_q[5]};
                pair_c_q <= {1'b0, win_q[2]} + {1'b0, win_q[4]};
                ctr_q    <= win_q[3];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: weighted sum, optional normalisation, output register
    // ------------------------------------------------------------------
    logic [OW-1:0] raw_d;
    logic [OW-1:0] val_d;

    // Weighted sum; peak is 64*(2^DATA_WIDTH-1), so OW bits never overflow
    always_comb begin
        raw_d = '0;
        if (pmode_q) begin
            raw_d = OW'(pair_a_q) + (OW'(pair_b_q) * C_K4) + (OW'(ctr_q) * C_K6);
        end else begin
            raw_d = OW'(pair_a_q) + (OW'(pair_b_q) * C_K8)
                  + (OW'(pair_c_q) * C_K14) + (OW'(ctr_q) * C_K18);
        end
    end

    // Adding the half-LSB rounding term stays below 2^OW for any input
    generate
        if (NORMALIZE != 0) begin : g_norm
            assign val_d = pmode_q ? ((raw_d + C_R8) >> 4) : ((raw_d + C_R32) >> 6);
        end else begin : g_raw
            assign val_d = raw_d;
        end
    endgenerate

    // Output register: value forced to zero whenever no result is present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_event_valid <= 1'b0;
            out_event_value <= '0;
        end else begin
            out_event_valid <= pv_q;
            out_event_value <= pv_q ? val_d : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gauss1d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gauss1d_stream
//  Description : Self-checking bench for gauss1d_stream. Drives raw and
//                normalised instances with identical lines and compares every
//                output against a clamped-index convolution model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gauss1d_stream;

    localparam int DW = 14;
    localparam int OW = DW + 6;

    logic          clk             = 1'b0;
    logic          rst_n           = 1'b0;
    logic          in_sample_valid = 1'b0;
    logic [DW-1:0] in_sample_value = '0;
    logic          in_last         = 1'b0;
    logic          in_mode         = 1'b0;

    logic          ready_r, ready_n;
    logic          valid_r, valid_n;
    logic [OW-1:0] value_r, value_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [OW-1:0] exp_raw  [$];
    logic [OW-1:0] exp_norm [$];
    int unsigned   cur_line [$];

    gauss1d_stream #(.DATA_WIDTH(DW), .NORMALIZE(0)) u_raw (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_sample_valid (in_sample_valid),
        .in_sample_value (in_sample_value),
        .in_last         (in_last),
        .in_mode         (in_mode),
        .in_ready        (ready_r),
        .out_event_value (value_r),
        .out_event_valid (valid_r)
    );

    gauss1d_stream #(.DATA_WIDTH(DW), .NORMALIZE(1)) u_norm (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_sample_valid (in_sample_valid),
        .in_sample_value (in_sample_value),
        .in_last         (in_last),
        .in_mode         (in_mode),
        .in_ready        (ready_n),
        .out_event_value (value_n),
        .out_event_valid (valid_n)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int kern(input bit m, input int k);
        int r;
        r = 0;
        if (m) begin
            case (k)
                0, 4:    r = 1;
                1, 3:    r = 4;
                2:       r = 6;
                default: r = 0;
            endcase
        end else begin
            case (k)
                0, 6:    r = 1;
                1, 5:    r = 8;
                2, 4:    r = 14;
                3:       r = 18;
                default: r = 0;
            endcase
        end
        return r;
    endfunction

    // Reference: output j is the kernel centred on sample j, indices clamped to the line
    task automatic push_expect(input bit m);
        int     L, c, n, idx, sh;
        longint s;
        L  = cur_line.size();
        c  = m ? 2 : 3;
        n  = m ? 5 : 7;
        sh = m ? 4 : 6;
        for (int j = 0; j < L; j++) begin
            s = 0;
            for (int k = 0; k < n; k++) begin
                idx = j + k - c;
                if (idx < 0)     idx = 0;
                if (idx > L - 1) idx = L - 1;
                s += longint'(kern(m, k)) * longint'(cur_line[idx]);
            end
            exp_raw.push_back(OW'(s));
            exp_norm.push_back(OW'((s + (longint'(1) << (sh - 1))) >> sh));
        end
    endtask

    // Output monitor: every valid output must match the next expected value
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_r === 1'b1) begin
                if (exp_raw.size() == 0) chk("raw_unexpected_valid", valid_r, 0);
                else                     chk("raw_value", value_r, exp_raw.pop_front());
            end else begin
                chk("raw_valid_known", valid_r, 0);
                chk("raw_idle_zero", value_r, 0);
            end
            if (valid_n === 1'b1) begin
                if (exp_norm.size() == 0) chk("norm_unexpected_valid", valid_n, 0);
                else                      chk("norm_value", value_n, exp_norm.pop_front());
            end else begin
                chk("norm_valid_known", valid_n, 0);
                chk("norm_idle_zero", value_n, 0);
            end
        end
    end

    task automatic send(input logic [DW-1:0] v, input logic last, input logic mode,
                        output int waited);
        int g;
        g = 0;
        @(negedge clk);
        in_sample_valid = 1'b1;
        in_sample_value = v;
        in_last         = last;
        in_mode         = mode;
        while (ready_r !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        waited = g;
        if (g >= 50) chk("accept_timeout", g, 0);
        @(posedge clk);
        #1;
        in_sample_valid = 1'b0;
        in_last         = 1'($urandom_range(0, 1));
        in_mode         = 1'($urandom_range(0, 1));
        in_sample_value = DW'($urandom);
    endtask

    task automatic send_line(input bit m, input bit gaps, output int first_wait);
        int w, L;
        L = cur_line.size();
        first_wait = 0;
        push_expect(m);
        for (int i = 0; i < L; i++) begin
            send(DW'(cur_line[i]), i == L - 1, (i == 0) ? m : ~m, w);
            if (i == 0) first_wait = w;
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        end
    endtask

    task automatic check_flush(input int h);
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            chk("flush_ready_low_raw", ready_r, 0);
            chk("flush_ready_low_norm", ready_n, 0);
        end
        @(negedge clk);
        chk("flush_ready_back", ready_r, 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_raw.size() != 0 || exp_norm.size() != 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain_raw_left", exp_raw.size(), 0);
        chk("drain_norm_left", exp_norm.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Constant-100 line of 8 with first-output latency and flush-length checks
    task automatic const_line_with_timing();
        int w;
        cur_line.delete();
        repeat (8) cur_line.push_back(100);
        push_expect(1'b0);
        for (int i = 0; i < 8; i++) begin
            send(DW'(100), i == 7, 1'b0, w);
            if (i == 3) begin
                @(negedge clk); chk("latency_t1_valid", valid_r, 0);
                @(negedge clk); chk("latency_t2_valid", valid_r, 0);
                @(negedge clk); chk("latency_t3_valid", valid_r, 1);
            end
        end
        check_flush(3);
        drain();
    endtask

    initial begin
        int fw, w, L;
        bit m;

        // Reset state
        #12;
        chk("reset_ready_raw", ready_r, 0);
        chk("reset_ready_norm", ready_n, 0);
        chk("reset_valid", valid_r, 0);
        chk("reset_value", value_r, 0);
        chk("reset_value_norm", value_n, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 7-tap constant line
        const_line_with_timing();

        // 7-tap impulse
        cur_line = '{0, 0, 0, 1000, 0, 0, 0};
        send_line(1'b0, 1'b0, fw);
        check_flush(3);
        drain();

        // 5-tap line with in_mode toggled after the first sample
        cur_line = '{10, 10, 20, 20};
        send_line(1'b1, 1'b0, fw);
        check_flush(2);
        drain();

        // Single-sample line followed back-to-back by the next line
        cur_line = '{5};
        send_line(1'b0, 1'b0, fw);
        cur_line = '{0, 0, 0, 2, 0, 0, 0};
        send_line(1'b0, 1'b0, fw);
        chk("back_to_back_wait", fw, 3);
        drain();

        // Randomised lines, including full-scale lines, mixed kernels and bubbles
        for (int r = 0; r < 24; r++) begin
            L = $urandom_range(1, 12);
            m = 1'($urandom_range(0, 1));
            cur_line.delete();
            for (int i = 0; i < L; i++) begin
                if (r % 6 == 5) cur_line.push_back((1 << DW) - 1);
                else            cur_line.push_back($urandom_range(0, (1 << DW) - 1));
            end
            send_line(m, 1'b1, fw);
        end
        drain();

        // Reset mid-line: aborted line produces nothing
        for (int i = 0; i < 4; i++) send(DW'(100), 1'b0, 1'b0, w);
        #1;
        rst_n = 1'b0;
        exp_raw.delete();
        exp_norm.delete();
        #1;
        chk("midreset_valid", valid_r, 0);
        chk("midreset_value", value_r, 0);
        chk("midreset_ready", ready_r, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", valid_r, 0);
        end
        const_line_with_timing();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
